// File: rtl/branch_update_ctrl.sv
// -----------------------------------------------------------------------------
// branch_update_ctrl
//
// Collects branch/jump resolutions from the EX stage into a small circular
// update queue. The queue drains one entry per cycle into the branch
// predictor / BTB update port whenever that port is available (hold = 0).
// At acceptance time the resolution is compared against the fetch-time
// prediction, and a registered single-cycle mispredict pulse with the
// correct fetch redirect address is produced. Two saturating 32-bit
// counters track resolved control-flow instructions and mispredictions.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rstn                synchronous active-low reset
//   res_valid/res_ready resolution handshake (ready = queue not full)
//   res_is_branch       resolution is a conditional branch
//   res_is_jump         resolution is an unconditional jump
//   res_taken           actual outcome
//   res_pc, res_target  PC and actual target of the resolved instruction
//   res_pred, res_hit   fetch-time direction prediction and BTB hit
//   res_pred_target     fetch-time predicted target
//   hold                predictor/BTB update port busy this cycle
//   update_predictor    write direction predictor (head is a branch)
//   update_btb          write BTB (head was taken)
//   actually_taken      head entry outcome (0 when empty)
//   resolved_pc         head entry PC (0 when empty)
//   resolved_pc_target  head entry target (0 when empty)
//   mispredict          registered one-cycle redirect request
//   redirect_pc         redirect address, held while mispredict = 0
//   branch_cnt          accepted resolutions, saturating
//   mispred_cnt         mispredictions, saturating
// -----------------------------------------------------------------------------
module branch_update_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic                  res_is_branch,
    input  logic                  res_is_jump,
    input  logic                  res_taken,
    input  logic [DATA_WIDTH-1:0] res_pc,
    input  logic [DATA_WIDTH-1:0] res_target,
    input  logic                  res_pred,
    input  logic                  res_hit,
    input  logic [DATA_WIDTH-1:0] res_pred_target,
    input  logic                  hold,
    output logic                  update_predictor,
    output logic                  update_btb,
    output logic                  actually_taken,
    output logic [DATA_WIDTH-1:0] resolved_pc,
    output logic [DATA_WIDTH-1:0] resolved_pc_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic                  is_branch;
        logic                  taken;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] target;
    } entry_t;

    entry_t                r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_mispredict;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic [31:0]           r_branch_cnt;
    logic [31:0]           r_mispred_cnt;

    logic                  w_not_empty;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_eff_taken;
    logic                  w_pred_taken;
    logic                  w_mis;
    logic [DATA_WIDTH-1:0] w_redirect;
    entry_t                w_head;
    entry_t                w_new_entry;

    assign w_not_empty = (r_count != '0);
    assign res_ready   = (r_count != FULL_CNT);

    // Only control-flow instructions occupy a slot; other handshakes are dropped.
    assign w_enq = res_valid && res_ready && (res_is_branch || res_is_jump);
    // Reset suppresses the update port so no stale entry leaks out while rstn = 0.
    assign w_deq = rstn && w_not_empty && !hold;

    // Jumps are unconditionally taken regardless of what EX reports.
    assign w_eff_taken  = res_taken || res_is_jump;
    assign w_pred_taken = res_hit && (res_pred || res_is_jump);
    assign w_mis        = (w_pred_taken != w_eff_taken) ||
                          (w_eff_taken && (res_pred_target != res_target));
    assign w_redirect   = w_eff_taken ? res_target : res_pc + DATA_WIDTH'(4);

    assign w_new_entry = '{is_branch: res_is_branch,
                           taken:     w_eff_taken,
                           pc:        res_pc,
                           target:    res_target};
    assign w_head      = r_mem[r_rd_ptr];

    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        update_predictor   = 1'b0;
        update_btb         = 1'b0;
        actually_taken     = 1'b0;
        resolved_pc        = '0;
        resolved_pc_target = '0;
        if (w_not_empty) begin
            actually_taken     = w_head.taken;
            resolved_pc        = w_head.pc;
            resolved_pc_target = w_head.target;
            update_predictor   = w_deq && w_head.is_branch;
            update_btb         = w_deq && w_head.taken;
        end
    end

    // NOTE: the entry storage is deliberately not reset; r_count alone
    // decides which slots are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= w_enq && w_mis;
            if (w_enq && w_mis) begin
                r_redirect_pc <= w_redirect;
            end
            if (w_enq && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_enq && w_mis && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_update_ctrl
//
// Self-checking bench for branch_update_ctrl. A queue-based reference model
// tracks pending updates, redirect state and counters from the behavioural
// rules; every cycle all outputs are compared against it at the falling edge.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_branch_update_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam longint unsigned CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstn;
    logic          res_valid;
    logic          res_ready;
    logic          res_is_branch;
    logic          res_is_jump;
    logic          res_taken;
    logic [DW-1:0] res_pc;
    logic [DW-1:0] res_target;
    logic          res_pred;
    logic          res_hit;
    logic [DW-1:0] res_pred_target;
    logic          hold;
    logic          update_predictor;
    logic          update_btb;
    logic          actually_taken;
    logic [DW-1:0] resolved_pc;
    logic [DW-1:0] resolved_pc_target;
    logic          mispredict;
    logic [DW-1:0] redirect_pc;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispred_cnt;

    always #5 clk = ~clk;

    branch_update_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_is_branch      (res_is_branch),
        .res_is_jump        (res_is_jump),
        .res_taken          (res_taken),
        .res_pc             (res_pc),
        .res_target         (res_target),
        .res_pred           (res_pred),
        .res_hit            (res_hit),
        .res_pred_target    (res_pred_target),
        .hold               (hold),
        .update_predictor   (update_predictor),
        .update_btb         (update_btb),
        .actually_taken     (actually_taken),
        .resolved_pc        (resolved_pc),
        .resolved_pc_target (resolved_pc_target),
        .mispredict         (mispredict),
        .redirect_pc        (redirect_pc),
        .branch_cnt         (branch_cnt),
        .mispred_cnt        (mispred_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_branch;
        bit          taken;
        bit [DW-1:0] pc;
        bit [DW-1:0] target;
    } ent_t;

    ent_t              mq[$];
    bit                m_misp;
    bit [DW-1:0]       m_redir;
    longint unsigned   m_bcnt;
    longint unsigned   m_mcnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit br, input bit jmp, input bit tk,
                         input bit [DW-1:0] pc, input bit [DW-1:0] tgt,
                         input bit pr, input bit hit, input bit [DW-1:0] ptgt,
                         input bit hd, input bit rn);
        res_valid       = v;
        res_is_branch   = br;
        res_is_jump     = jmp;
        res_taken       = tk;
        res_pc          = pc;
        res_target      = tgt;
        res_pred        = pr;
        res_hit         = hit;
        res_pred_target = ptgt;
        hold            = hd;
        rstn            = rn;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic compare_all();
        ent_t h;
        bit   deq;
        h   = '{default: 0};
        if (mq.size() != 0) h = mq[0];
        deq = rstn && (mq.size() != 0) && !hold;
        check("res_ready",          64'(res_ready),          64'(mq.size() != DEPTH));
        check("update_predictor",   64'(update_predictor),   64'(deq && h.is_branch));
        check("update_btb",         64'(update_btb),         64'(deq && h.taken));
        check("actually_taken",     64'(actually_taken),     64'(h.taken));
        check("resolved_pc",        64'(resolved_pc),        64'(h.pc));
        check("resolved_pc_target", 64'(resolved_pc_target), 64'(h.target));
        check("mispredict",         64'(mispredict),         64'(m_misp));
        check("redirect_pc",        64'(redirect_pc),        64'(m_redir));
        check("branch_cnt",         64'(branch_cnt),         m_bcnt);
        check("mispred_cnt",        64'(mispred_cnt),        m_mcnt);
    endtask

    // Advance the model by one clock edge using the inputs in force.
    task automatic model_update();
        bit acc, deq, taken, pred_taken, mis;
        if (!rstn) begin
            mq.delete();
            m_misp  = 1'b0;
            m_redir = '0;
            m_bcnt  = 0;
            m_mcnt  = 0;
            return;
        end
        acc        = res_valid && (mq.size() != DEPTH) && (res_is_branch || res_is_jump);
        deq        = (mq.size() != 0) && !hold;
        taken      = res_taken || res_is_jump;
        pred_taken = res_hit && (res_pred || res_is_jump);
        mis        = (pred_taken != taken) || (taken && (res_pred_target != res_target));
        m_misp     = acc && mis;
        if (acc && mis) m_redir = taken ? res_target : res_pc + 32'd4;
        if (acc && m_bcnt < CNT_MAX) m_bcnt++;
        if (acc && mis && m_mcnt < CNT_MAX) m_mcnt++;
        if (deq) void'(mq.pop_front());
        if (acc) mq.push_back('{res_is_branch, taken, res_pc, res_target});
    endtask

    task automatic apply(input bit v, input bit br, input bit jmp, input bit tk,
                         input bit [DW-1:0] pc, input bit [DW-1:0] tgt,
                         input bit pr, input bit hit, input bit [DW-1:0] ptgt,
                         input bit hd, input bit rn);
        drive(v, br, jmp, tk, pc, tgt, pr, hit, ptgt, hd, rn);
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_idle(input bit hd, input bit rn);
        apply(0, 0, 0, 0, '0, '0, 0, 0, '0, hd, rn);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        // Bring the design out of its unknown power-up state.
        drive(0, 0, 0, 0, '0, '0, 0, 0, '0, 0, 0);
        @(posedge clk);
        tick();
        apply_idle(0, 0);
        check("rst_ready", 64'(res_ready), 64'd1);
        tick();

        // Correctly predicted taken branch.
        apply(1, 1, 0, 1, 32'h100, 32'h80, 1, 1, 32'h80, 0, 1);
        tick();
        apply_idle(0, 1);
        check("tb_hit_misp",     64'(mispredict),         64'd0);
        check("tb_hit_upd_pred", 64'(update_predictor),   64'd1);
        check("tb_hit_upd_btb",  64'(update_btb),         64'd1);
        check("tb_hit_pc",       64'(resolved_pc),        64'h100);
        check("tb_hit_tgt",      64'(resolved_pc_target), 64'h80);
        tick();

        // Predicted taken, actually not taken.
        apply(1, 1, 0, 0, 32'h200, 32'h999, 1, 1, 32'h250, 0, 1);
        tick();
        apply_idle(0, 1);
        check("nt_misp",     64'(mispredict),       64'd1);
        check("nt_redirect", 64'(redirect_pc),      64'h204);
        check("nt_upd_btb",  64'(update_btb),       64'd0);
        check("nt_upd_pred", 64'(update_predictor), 64'd1);
        tick();
        apply_idle(0, 1);
        check("nt_pulse_end",   64'(mispredict),  64'd0);
        check("nt_redir_held",  64'(redirect_pc), 64'h204);
        tick();

        // Jump missing in the BTB.
        apply(1, 0, 1, 1, 32'h300, 32'h400, 0, 0, '0, 0, 1);
        tick();
        apply_idle(0, 1);
        check("jmp_misp",     64'(mispredict),       64'd1);
        check("jmp_redirect", 64'(redirect_pc),      64'h400);
        check("jmp_upd_pred", 64'(update_predictor), 64'd0);
        check("jmp_upd_btb",  64'(update_btb),       64'd1);
        tick();

        // Fill under hold, then drain in order.
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, 0, 1, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i),
                  1, 1, 32'h2000 + 32'(4 * i), 1, 1);
            check("fill_ready", 64'(res_ready), 64'(i < DEPTH));
            tick();
        end
        apply(1, 1, 0, 1, 32'h1010, 32'h2010, 1, 1, 32'h2010, 1, 1);
        check("fifth_waits", 64'(res_ready), 64'd0);
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            apply_idle(0, 1);
            check("drain_pc",  64'(resolved_pc),      64'h1000 + 64'(4 * k));
            check("drain_upd", 64'(update_predictor), 64'd1);
            tick();
        end
        apply_idle(0, 1);
        check("drain_empty", 64'(update_predictor), 64'd0);
        tick();

        // Reset with entries pending.
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 0, 0, 32'h3000 + 32'(4 * i), 32'h0, 0, 0, 32'h0, 1, 1);
            tick();
        end
        apply_idle(0, 0);
        check("rst_mid_upd_pred", 64'(update_predictor), 64'd0);
        check("rst_mid_upd_btb",  64'(update_btb),       64'd0);
        tick();
        apply_idle(0, 1);
        check("rst_rel_ready", 64'(res_ready),        64'd1);
        check("rst_rel_upd",   64'(update_predictor), 64'd0);
        check("rst_rel_pc",    64'(resolved_pc),      64'd0);
        check("rst_rel_bcnt",  64'(branch_cnt),       64'd0);
        check("rst_rel_mcnt",  64'(mispred_cnt),      64'd0);
        tick();

        // Misprediction counter saturation from a preloaded value.
        force dut.r_mispred_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_mispred_cnt;
        m_mcnt = 64'h0000_0000_FFFF_FFFD;
        for (int i = 0; i < 6; i++) begin
            apply(1, 1, 0, 0, 32'h5000 + 32'(4 * i), 32'h0, 1, 1, 32'h0, 0, 1);
            tick();
        end
        apply_idle(0, 1);
        check("mcnt_saturated", 64'(mispred_cnt), 64'h0000_0000_FFFF_FFFF);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            int unsigned kind;
            bit          br, jmp, tk;
            bit [DW-1:0] pc, tgt, ptgt;
            kind = $urandom_range(0, 9);
            br   = (kind < 5);
            jmp  = (kind >= 5) && (kind < 8);
            tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            tgt  = $urandom() & 32'hFFFF_FFFC;
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : ($urandom() & 32'hFFFF_FFFC);
            apply(1'($urandom_range(0, 9) < 7), br, jmp, tk, pc, tgt,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ptgt,
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 99) != 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning PC/target width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning update-queue entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port res_valid, input, 1, meaning an EX-stage resolution is presented.
REQ-006 SHALL have port res_ready, output, 1, meaning the queue is not full; the resolution is accepted when res_valid and res_ready are both 1.
REQ-007 SHALL have ports res_is_branch and res_is_jump, input, 1 each, meaning conditional branch or unconditional jump.
REQ-008 SHALL have ports res_taken, input, 1, res_pc, input, DATA_WIDTH, and res_target, input, DATA_WIDTH, meaning the actual outcome, the PC and the actual target.
REQ-009 SHALL have ports res_pred, input, 1, res_hit, input, 1, and res_pred_target, input, DATA_WIDTH, meaning the prediction made at fetch.
REQ-010 SHALL have port hold, input, 1, meaning the predictor/BTB update port is unavailable this cycle.
REQ-011 SHALL have ports update_predictor, output, 1, update_btb, output, 1, actually_taken, output, 1, resolved_pc, output, DATA_WIDTH, and resolved_pc_target, output, DATA_WIDTH, meaning the update interface to the branch predictor and BTB.
REQ-012 SHALL have ports mispredict, output, 1, and redirect_pc, output, DATA_WIDTH, meaning a fetch redirect request.
REQ-013 SHALL have ports branch_cnt and mispred_cnt, output, 32 each, meaning statistics counters.

Function
REQ-014 SHALL accept only when the handshake holds and (res_is_branch or res_is_jump); a handshake with both 0 SHALL be dropped without enqueue or mispredict.
REQ-015 SHALL store {is_branch, taken, pc, target} per accepted entry in a circular FIFO of DEPTH entries with wrapping read/write pointers and an occupancy count from 0 to DEPTH.
REQ-016 SHALL drive res_ready = (count != DEPTH); when full, it SHALL stay 0 even if a dequeue occurs in the same cycle.
REQ-017 SHALL dequeue the head when count != 0 and hold = 0, exactly one entry per cycle.
REQ-018 SHALL drive update_predictor = dequeue and head.is_branch, combinationally.
REQ-019 SHALL drive update_btb = dequeue and head.taken; jumps are always taken.
REQ-020 SHALL drive actually_taken, resolved_pc and resolved_pc_target from the head entry whenever count != 0, and SHALL drive them 0 when empty.
REQ-021 SHALL, on a simultaneous enqueue and dequeue with 1 <= count < DEPTH, leave count unchanged.
REQ-022 SHALL allow an enqueue into an empty queue to appear at the outputs no earlier than the next cycle, with no bypass, giving an update latency of at least 1 cycle.
REQ-023 SHALL compute, for an accepted entry, predicted-taken = res_hit and (res_pred or res_is_jump).
REQ-024 SHALL flag an accepted entry as mispredicted if predicted-taken != res_taken, or if res_taken and res_pred_target != res_target.
REQ-025 SHALL register mispredict 1 cycle after acceptance as a single-cycle pulse.
REQ-026 SHALL register redirect_pc in the same cycle as mispredict: res_target if taken, otherwise res_pc + 4 modulo 2^DATA_WIDTH.
REQ-027 SHALL hold redirect_pc at its last value when mispredict = 0.
REQ-028 SHALL increment branch_cnt per accepted entry and mispred_cnt per mispredict, both saturating at 0xFFFFFFFF.
REQ-029 SHALL never change queue state while hold = 1, except for enqueue.

Reset
REQ-030 SHALL, when rstn = 0 at a clock edge, clear count and pointers and clear mispredict, redirect_pc, branch_cnt and mispred_cnt to 0.
REQ-031 SHALL, while in reset, leave res_ready = 1, which follows from count = 0, with all update outputs 0.
REQ-032 SHALL discard queued entries on reset mid-operation, and SHALL issue no update in the cycle after reset release.

Verification
REQ-033 SHALL pass: a taken branch with pc=0x100, target=0x80, hit=1, pred=1 -> mispredict stays 0; the next cycle gives update_predictor=1, update_btb=1, resolved_pc=0x100, resolved_pc_target=0x80.
REQ-034 SHALL pass: a not-taken branch with pc=0x200, hit=1, pred=1 -> one cycle later mispredict=1 and redirect_pc=0x204; update_btb=0 when dequeued.
REQ-035 SHALL pass: a jump with pc=0x300, target=0x400, hit=0 -> mispredict=1, redirect_pc=0x400, update_predictor=0, update_btb=1.
REQ-036 SHALL pass: hold=1 with 5 back-to-back accepts at DEPTH=4 -> res_ready=0 after the 4th, the 5th waits; releasing hold drains 4 updates in FIFO order on consecutive cycles.
REQ-037 SHALL pass: 3 entries queued and rstn=0 for 1 cycle -> count=0, no updates issued, counters=0.
REQ-038 SHALL pass: mispred_cnt preloaded near max via a long stream -> it holds at 0xFFFFFFFF without wrapping.
